// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state and SPI mode encodings for the SPI master
package spi_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} spiState;
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCLK half-period divider with leading/trailing edge strobes
module spi_clk_gen #(
    parameter int HALF_PERIOD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic cpol,
    output logic leadStb,
    output logic trailStb,
    output logic sclk
);
    localparam int CW = $clog2(HALF_PERIOD + 1);
    logic [CW-1:0] cnt;
    logic lvl, stb;
    assign stb = en && cnt == CW'(HALF_PERIOD - 1);
    assign leadStb = stb && !lvl;
    assign trailStb = stb && lvl;
    // lvl counts toggles away from idle, so SCLK follows a newly latched cpol at once
    assign sclk = cpol ^ lvl;
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else begin
            cnt <= stb ? '0 : cnt + CW'(1);
            lvl <= lvl ^ stb;
        end
    end
endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master with run-time mode, bit order and slave select
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 3,
    parameter int SS_W = NUM_SS > 1 ? $clog2(NUM_SS) : 1,
    parameter int HALF_PERIOD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SS_W-1:0]   slaveSelect,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DATA_W-1:0] MasterDataToSend,
    output logic [DATA_W-1:0] MasterDataReceived,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              SCLK,
    output logic [NUM_SS-1:0] CS,
    output logic              MDO,
    input  logic              MDI
);
    localparam int BW = $clog2(DATA_W);
    localparam int CW = $clog2(HALF_PERIOD + 1);
    spiState state;
    logic [1:0] modeReg;
    logic lsbReg, cpolR, cphaR, leadStb, trailStb, valid;
    logic [DATA_W-1:0] txReg, rxReg;
    logic [BW-1:0] bitCnt, nxtCnt, curIdx, nxtIdx;
    logic [CW-1:0] holdCnt;
    assign cpolR = modeReg == MODE2 || modeReg == MODE3;
    assign cphaR = modeReg == MODE1 || modeReg == MODE3;
    assign valid = 32'(slaveSelect) < NUM_SS;
    assign nxtCnt = bitCnt == BW'(DATA_W - 1) ? bitCnt : bitCnt + BW'(1);
    assign curIdx = lsbReg ? bitCnt : BW'(DATA_W - 1) - bitCnt;
    assign nxtIdx = lsbReg ? nxtCnt : BW'(DATA_W - 1) - nxtCnt;
    spi_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) clkGen (
        .clk(clk),
        .reset(reset),
        .en(state == ACTIVE),
        .cpol(cpolR),
        .leadStb(leadStb),
        .trailStb(trailStb),
        .sclk(SCLK)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            CS <= '1;
            MDO <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            MasterDataReceived <= '0;
            modeReg <= MODE0;
            lsbReg <= 1'b0;
            txReg <= '0;
            rxReg <= '0;
            bitCnt <= '0;
            holdCnt <= '0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (valid) begin
                        state <= ACTIVE;
                        busy <= 1'b1;
                        CS <= ~(NUM_SS'(1) << slaveSelect);
                        modeReg <= {cpol, cpha};
                        lsbReg <= lsb_first;
                        txReg <= MasterDataToSend;
                        bitCnt <= '0;
                        MDO <= cpha ? 1'b0 : MasterDataToSend[lsb_first ? BW'(0) : BW'(DATA_W - 1)];
                    end else begin
                        err <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (leadStb) begin
                        if (cphaR) MDO <= txReg[curIdx];
                        else rxReg[curIdx] <= MDI;
                    end
                    if (trailStb) begin
                        if (cphaR) rxReg[curIdx] <= MDI;
                        else MDO <= txReg[nxtIdx];
                        bitCnt <= nxtCnt;
                        if (bitCnt == BW'(DATA_W - 1)) begin
                            state <= HOLD;
                            holdCnt <= '0;
                        end
                    end
                end
                HOLD: if (holdCnt == CW'(HALF_PERIOD - 1)) begin
                    state <= IDLE;
                    CS <= '1;
                    busy <= 1'b0;
                    done <= 1'b1;
                    MDO <= 1'b0;
                    MasterDataReceived <= rxReg;
                end else begin
                    holdCnt <= holdCnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: randomized bench against a behavioural SPI slave and timing model
module tb_spi_master_param;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] start = '0;
    logic [1:0] slaveSelect = '0;
    logic cpol = 1'b0, cpha = 1'b0, lsbFirst = 1'b0, mdi = 1'b0;
    logic [W-1:0] txWord = '0;
    logic [1:0][W-1:0] rx;
    logic [1:0][2:0] cs;
    logic [1:0] busy, done, err, sclk, mdo;
    int checks = 0, errors = 0, u = 0;
    logic [W-1:0] slvWord = '0, slvGot = '0;
    int slvIdx = 0;
    logic prevSel = 1'b0, prevSclk = 1'b0;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(W), .NUM_SS(3), .HALF_PERIOD(1)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .slaveSelect(slaveSelect),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsbFirst), .MasterDataToSend(txWord),
        .MasterDataReceived(rx[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
        .SCLK(sclk[0]), .CS(cs[0]), .MDO(mdo[0]), .MDI(mdi)
    );
    spi_master_param #(.DATA_W(W), .NUM_SS(3), .HALF_PERIOD(4)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .slaveSelect(slaveSelect),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsbFirst), .MasterDataToSend(txWord),
        .MasterDataReceived(rx[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
        .SCLK(sclk[1]), .CS(cs[1]), .MDO(mdo[1]), .MDI(mdi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bitPos(input int i);
        return lsbFirst ? i : W - 1 - i;
    endfunction

    // Slave: shifts its word out and captures MDO according to the selected SPI mode
    always @(negedge clk) begin
        logic sel, sc;
        sel = cs[u] != 3'b111;
        sc = sclk[u];
        if (sel && !prevSel) begin
            slvIdx = 0;
            slvGot = '0;
            if (!cpha) mdi = slvWord[bitPos(0)];
        end else if (sel && sc != prevSclk && slvIdx < W) begin
            if (sc != cpol) begin
                if (cpha) mdi = slvWord[bitPos(slvIdx)];
                else slvGot[bitPos(slvIdx)] = mdo[u];
            end else begin
                if (cpha) slvGot[bitPos(slvIdx)] = mdo[u];
                slvIdx++;
                if (!cpha && slvIdx < W) mdi = slvWord[bitPos(slvIdx)];
            end
        end
        prevSel = sel;
        prevSclk = sc;
    end

    task automatic setup(input int unit, input logic [1:0] sel, input logic [1:0] mode,
                         input logic lsb, input logic [W-1:0] tx, input logic [W-1:0] sw);
        u = unit;
        slaveSelect = sel;
        {cpol, cpha} = mode;
        lsbFirst = lsb;
        txWord = tx;
        slvWord = sw;
    endtask

    task automatic transfer(input string tag, input int unit, input logic [1:0] sel, input logic [1:0] mode,
                            input logic lsb, input logic [W-1:0] tx, input logic [W-1:0] sw);
        int n = 0, edges = 0, hp;
        logic edgeOk = 1'b1, csOk = 1'b1, last;
        hp = unit ? 4 : 1;
        @(negedge clk);
        setup(unit, sel, mode, lsb, tx, sw);
        start[unit] = 1'b1;
        @(posedge clk);
        #1 start[unit] = 1'b0;
        last = cpol;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (done[unit]) break;
            if (n == 1) begin
                check({tag, " sclk cycle1"}, 32'(sclk[unit]), 32'(cpol));
                check({tag, " busy cycle1"}, 32'(busy[unit]), 1);
            end
            if (cs[unit] !== ~(3'b001 << sel)) csOk = 1'b0;
            if (sclk[unit] !== last) begin
                edges++;
                if (n != 1 + edges * hp) edgeOk = 1'b0;
                last = sclk[unit];
            end
        end
        check({tag, " done cycle"}, 32'(n), 32'(1 + (2 * W + 1) * hp));
        check({tag, " rx word"}, 32'(rx[unit]), 32'(sw));
        check({tag, " slave got"}, 32'(slvGot), 32'(tx));
        check({tag, " edge count"}, 32'(edges), 2 * W);
        check({tag, " edge timing"}, 32'(edgeOk), 1);
        check({tag, " cs during"}, 32'(csOk), 1);
        check({tag, " cs after"}, 32'(cs[unit]), 32'h7);
        check({tag, " busy after"}, 32'(busy[unit]), 0);
        check({tag, " sclk idle"}, 32'(sclk[unit]), 32'(cpol));
        @(negedge clk);
        check({tag, " done width"}, 32'(done[unit]), 0);
    endtask

    initial begin
        int dones;
        logic gotDone;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset sclk", 32'(sclk[d]), 0);
            check("reset cs", 32'(cs[d]), 32'h7);
            check("reset mdo", 32'(mdo[d]), 0);
            check("reset busy", 32'(busy[d]), 0);
            check("reset done", 32'(done[d]), 0);
            check("reset err", 32'(err[d]), 0);
            check("reset rx", 32'(rx[d]), 0);
        end
        reset = 1'b0;

        transfer("mode0", 0, 2'd0, 2'b00, 1'b0, 8'hA5, 8'h3C);
        transfer("mode3 lsb", 0, 2'd2, 2'b11, 1'b1, 8'h81, 8'h7E);
        transfer("hp4 mode1", 1, 2'd0, 2'b01, 1'b0, 8'hF0, 8'h0F);
        for (int i = 0; i < 16; i++)
            transfer("rnd", 0, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        for (int i = 0; i < 3; i++)
            transfer("rnd hp4", 1, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), W'($urandom), W'($urandom));

        @(negedge clk);
        setup(0, 2'd3, 2'b00, 1'b0, 8'h55, 8'h00);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        @(negedge clk);
        check("bad sel err", 32'(err[0]), 1);
        check("bad sel cs", 32'(cs[0]), 32'h7);
        check("bad sel busy", 32'(busy[0]), 0);
        @(negedge clk);
        check("bad sel err width", 32'(err[0]), 0);
        check("bad sel done", 32'(done[0]), 0);
        check("bad sel cs later", 32'(cs[0]), 32'h7);

        transfer("pre reset", 0, 2'd1, 2'b10, 1'b0, 8'h12, 8'hE7);
        @(negedge clk);
        setup(0, 2'd1, 2'b11, 1'b0, 8'h99, 8'h66);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("mid busy", 32'(busy[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid reset cs", 32'(cs[0]), 32'h7);
        check("mid reset sclk", 32'(sclk[0]), 0);
        check("mid reset busy", 32'(busy[0]), 0);
        check("mid reset rx", 32'(rx[0]), 0);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            dones += int'(done[0]);
        end
        check("mid reset no done", 32'(dones), 0);

        @(negedge clk);
        setup(0, 2'd1, 2'b00, 1'b0, 8'h5A, 8'hC3);
        start[0] = 1'b1;
        dones = 0;
        gotDone = 1'b0;
        for (int c = 0; c < 100 && !gotDone; c++) begin
            @(negedge clk);
            gotDone = done[0];
        end
        check("b2b first done", 32'(gotDone), 1);
        dones += int'(gotDone);
        check("b2b rx1", 32'(rx[0]), 32'hC3);
        @(negedge clk);
        check("b2b cs low", 32'(cs[0]), 32'h5);
        check("b2b busy", 32'(busy[0]), 1);
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (60) begin
            @(negedge clk);
            dones += int'(done[0]);
        end
        check("b2b transfers", 32'(dones), 2);
        check("b2b rx2", 32'(rx[0]), 32'hC3);
        check("b2b slave got", 32'(slvGot), 32'h5A);
        check("b2b cs idle", 32'(cs[0]), 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
